// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters: arbitration, operand and response registers.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_opa,
  input  logic [NUM_REQ*32-1:0] req_opb,
  input  logic [NUM_REQ*4-1:0]  req_opcode,
  output logic [31:0]           alu_operand_a,
  output logic [31:0]           alu_operand_b,
  output logic [3:0]            alu_opcode,
  input  logic [31:0]           alu_result,
  input  logic                  alu_z,
  input  logic                  alu_v,
  input  logic                  alu_n,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [31:0]           rsp_result,
  output logic                  rsp_z,
  output logic                  rsp_v,
  output logic                  rsp_n,
  output logic [15:0]           op_count
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // req_ready is combinational from req_valid, so requesters must not derive req_valid from it.
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t         state;
  state_t         state_next;
  logic [IDW-1:0] grant_id;
  logic           grant_any;
  logic           accept;
  logic           take;
  logic           rsp_hs;
  logic [IDW-1:0] inflight_id;
  logic [31:0]    sel_opa;
  logic [31:0]    sel_opb;
  logic [3:0]     sel_opcode;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_any = 1'b1;
        grant_id  = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0] rr_ptr;

  // Distance of requester i from the slot after the pointer; nearest valid requester wins.
  always_comb begin
    int best_d;
    int d;
    grant_any = 1'b0;
    grant_id  = '0;
    best_d    = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i + NUM_REQ - 1 - int'(rr_ptr)) % NUM_REQ;
      if (req_valid[i] && d < best_d) begin
        best_d    = d;
        grant_any = 1'b1;
        grant_id  = IDW'(i);
      end
    end
  end
`endif

  assign accept = (state == IDLE) || ((state == DONE) && rsp_ready);
  assign take   = accept && grant_any;
  assign rsp_hs = rsp_valid && rsp_ready;

  always_comb begin
    req_ready  = '0;
    sel_opa    = '0;
    sel_opb    = '0;
    sel_opcode = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        req_ready[i] = take;
        sel_opa      = req_opa[32*i +: 32];
        sel_opb      = req_opb[32*i +: 32];
        sel_opcode   = req_opcode[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take) state_next = EXEC;
      EXEC:    state_next = DONE;
      DONE:    if (rsp_ready) state_next = take ? EXEC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      alu_opcode    <= '0;
      inflight_id   <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_result    <= '0;
      rsp_z         <= 1'b0;
      rsp_v         <= 1'b0;
      rsp_n         <= 1'b0;
      op_count      <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_ptr        <= IDW'(NUM_REQ - 1);
`endif
    end else begin
      state <= state_next;
      if (take) begin
        alu_operand_a <= sel_opa;
        alu_operand_b <= sel_opb;
        alu_opcode    <= sel_opcode;
        inflight_id   <= grant_id;
`ifndef ALU_ARB_FIXED_PRIO_EN
        rr_ptr        <= grant_id;
`endif
      end
      if (state == EXEC) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= inflight_id;
        rsp_result <= alu_result;
        rsp_z      <= alu_z;
        rsp_v      <= alu_v;
        rsp_n      <= alu_n;
      end else if (rsp_hs) begin
        rsp_valid <= 1'b0;
      end
      if (rsp_hs) op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small add/sub/and ALU model hanging off the ALU ports.
module tb_alu_share_arbiter;

  localparam int NUM_REQ = 2;
  localparam int IDW     = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_opa = '0;
  logic [NUM_REQ*32-1:0] req_opb = '0;
  logic [NUM_REQ*4-1:0]  req_opcode = '0;
  logic [31:0]           alu_operand_a;
  logic [31:0]           alu_operand_b;
  logic [3:0]            alu_opcode;
  logic [31:0]           alu_result;
  logic                  alu_z;
  logic                  alu_v;
  logic                  alu_n;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [IDW-1:0]        rsp_id;
  logic [31:0]           rsp_result;
  logic                  rsp_z;
  logic                  rsp_v;
  logic                  rsp_n;
  logic [15:0]           op_count;

  int total = 0;
  int bad   = 0;

  alu_share_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb), .req_opcode(req_opcode),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_z(rsp_z), .rsp_v(rsp_v), .rsp_n(rsp_n),
    .op_count(op_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ALU model: 0 add, 2 sub, anything else and
  always_comb begin
    alu_v = 1'b0;
    case (alu_opcode)
      4'd0: begin
        alu_result = alu_operand_a + alu_operand_b;
        alu_v = (alu_operand_a[31] == alu_operand_b[31]) && (alu_result[31] != alu_operand_a[31]);
      end
      4'd2: begin
        alu_result = alu_operand_a - alu_operand_b;
        alu_v = (alu_operand_a[31] != alu_operand_b[31]) && (alu_result[31] != alu_operand_a[31]);
      end
      default: alu_result = alu_operand_a & alu_operand_b;
    endcase
    alu_z = (alu_result == 32'd0);
    alu_n = alu_result[31];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    req_opa[32*i +: 32]  = a;
    req_opb[32*i +: 32]  = b;
    req_opcode[4*i +: 4] = op;
  endtask

  task automatic reset_dut();
    req_valid = '0;
    rsp_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [2:0] flags();
    return {rsp_z, rsp_v, rsp_n};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    int g;
    #1 rst = 1'b1;
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
    check_eq("rst_rsp_result", rsp_result, 32'd0);
    check_eq("rst_flags", 32'(flags()), 32'd0);
    check_eq("rst_op_count", 32'(op_count), 32'd0);
    check_eq("rst_alu_a", alu_operand_a, 32'd0);
    @(negedge clk);
    tick();
    rst = 1'b0;

    // single request: 5 + 3
    set_op(0, 32'd5, 32'd3, 4'd0);
    req_valid = 2'b01;
    #1 check_eq("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    #1;
    check_eq("single_exec_ready", 32'(req_ready), 32'd0);
    check_eq("single_exec_valid", 32'(rsp_valid), 32'd0);
    check_eq("single_alu_a", alu_operand_a, 32'd5);
    check_eq("single_alu_b", alu_operand_b, 32'd3);
    tick();
    check_eq("single_valid", 32'(rsp_valid), 32'd1);
    check_eq("single_id", 32'(rsp_id), 32'd0);
    check_eq("single_result", rsp_result, 32'd8);
    check_eq("single_flags", 32'(flags()), 32'd0);
    rsp_ready = 1'b1;
    tick();
    check_eq("single_count", 32'(op_count), 32'd1);
    check_eq("single_drop", 32'(rsp_valid), 32'd0);

    // contention, back-to-back responses
    reset_dut();
    set_op(0, 32'd10, 32'd1, 4'd0);
    set_op(1, 32'd20, 32'd1, 4'd0);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    for (int n = 0; n < 4; n++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      g = 0;
`else
      g = n % 2;
`endif
      check_eq("rr_grant", 32'(req_ready), 32'(1 << g));
      tick();
      check_eq("rr_exec_ready", 32'(req_ready), 32'd0);
      check_eq("rr_exec_valid", 32'(rsp_valid), 32'd0);
      tick();
      check_eq("rr_valid", 32'(rsp_valid), 32'd1);
      check_eq("rr_id", 32'(rsp_id), 32'(g));
      check_eq("rr_result", rsp_result, (g == 1) ? 32'd21 : 32'd11);
    end
    req_valid = 2'b00;
    tick();
    check_eq("rr_idle_valid", 32'(rsp_valid), 32'd0);
    check_eq("rr_count", 32'(op_count), 32'd4);

    // backpressure: 3 - 3 held for 5 cycles
    rsp_ready = 1'b0;
    set_op(0, 32'd3, 32'd3, 4'd2);
    req_valid = 2'b01;
    #1 check_eq("bp_grant", 32'(req_ready), 32'h1);
    tick();
    tick();
    for (int n = 0; n < 5; n++) begin
      check_eq("bp_valid", 32'(rsp_valid), 32'd1);
      check_eq("bp_result", rsp_result, 32'd0);
      check_eq("bp_flags", 32'(flags()), 32'h4);
      check_eq("bp_ready", 32'(req_ready), 32'd0);
      check_eq("bp_alu_a", alu_operand_a, 32'd3);
      check_eq("bp_alu_b", alu_operand_b, 32'd3);
      check_eq("bp_alu_op", 32'(alu_opcode), 32'd2);
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    tick();
    check_eq("bp_count", 32'(op_count), 32'd5);
    check_eq("bp_drop", 32'(rsp_valid), 32'd0);

    // signed overflow
    rsp_ready = 1'b0;
    set_op(0, 32'h7FFF_FFFF, 32'd1, 4'd0);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    check_eq("ovf_result", rsp_result, 32'h8000_0000);
    check_eq("ovf_flags", 32'(flags()), 32'h3);
    check_eq("ovf_count_hold", 32'(op_count), 32'd5);
    rsp_ready = 1'b1;
    tick();
    check_eq("ovf_count", 32'(op_count), 32'd6);
    rsp_ready = 1'b0;

    // asynchronous reset during EXEC
    set_op(0, 32'd9, 32'd9, 4'd0);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid", 32'(rsp_valid), 32'd0);
    check_eq("arst_count", 32'(op_count), 32'd0);
    check_eq("arst_alu_a", alu_operand_a, 32'd0);
    check_eq("arst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    tick();
    rst = 1'b0;
    check_eq("arst_no_rsp0", 32'(rsp_valid), 32'd0);
    tick();
    check_eq("arst_no_rsp1", 32'(rsp_valid), 32'd0);
    set_op(1, 32'd7, 32'd8, 4'd0);
    req_valid = 2'b10;
    #1 check_eq("arst_grant1", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    tick();
    check_eq("arst_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("arst_rsp_id", 32'(rsp_id), 32'd1);
    check_eq("arst_rsp_result", rsp_result, 32'd15);

    // op_count wrap from 0xFFFF on the pending handshake
    force dut.op_count = 16'hFFFF;
    #1 check_eq("wrap_pre", 32'(op_count), 32'h0000_FFFF);
    release dut.op_count;
    rsp_ready = 1'b1;
    tick();
    check_eq("wrap_count", 32'(op_count), 32'd0);
    check_eq("wrap_drop", 32'(rsp_valid), 32'd0);

`ifdef ALU_ARB_FIXED_PRIO_EN
    set_op(0, 32'd1, 32'd1, 4'd0);
    set_op(1, 32'd2, 32'd2, 4'd0);
    req_valid = 2'b11;
    #1;
    for (int n = 0; n < 3; n++) begin
      check_eq("fp_grant", 32'(req_ready), 32'h1);
      tick();
      tick();
      check_eq("fp_id", 32'(rsp_id), 32'd0);
    end
    req_valid = 2'b00;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
